wb_stage: RTL and testbench

- Write-back stage driving the single shared register-file write port: W_write_enable, W_write_enable_f, W_rd, W_rd_data.
- Merges two result sources: the in-order pipeline result arriving from MEM (ALU result or load data) and an out-of-order long-latency unit (mul/div/fdiv) using a valid/ready handshake.
- Long-latency results wait in a small FIFO. Pipeline results win the port.
- A starvation counter requests a one-cycle pipeline stall so the FIFO is never starved.

---
 rtl/wb_stage.sv | 170 +++++++++++++++++
 tb/tb_wb_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates the single register-file write port between the
// in-order MEM result and a small FIFO of out-of-order long-latency results.
module wb_stage #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_valid,
    input  logic [4:0]  M_rd,
    input  logic        M_reg_write_enable,
    input  logic        M_reg_write_enable_f,
    input  logic        M_wb_data_sel,
    input  logic [2:0]  M_funct3,
    input  logic [1:0]  M_addr_lo,
    input  logic [31:0] M_alu_result,
    input  logic [31:0] M_ld_data,
    input  logic        L_valid,
    output logic        L_ready,
    input  logic [4:0]  L_rd,
    input  logic        L_is_fp,
    input  logic [31:0] L_data,
    output logic        L_pending,
    output logic        W_write_enable,
    output logic        W_write_enable_f,
    output logic [4:0]  W_rd,
    output logic [31:0] W_rd_data,
    output logic        W_stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam int ENT_W = 38;

    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [STV_W-1:0] starve_reg, starve_next;
    logic             stall_reg, stall_next;
    logic             we_reg, we_next;
    logic             we_f_reg, we_f_next;
    logic [4:0]       rd_reg, rd_next;
    logic [31:0]      data_reg, data_next;

    logic             push, pop, fifo_nonempty, m_eligible;
    logic [ENT_W-1:0] head;
    logic             head_fp;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    logic [7:0]       ld_bytes  [4];
    logic [15:0]      ld_halves [2];
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_fmt;

    // Byte and halfword lanes of the aligned load word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign ld_bytes[gi] = M_ld_data[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign ld_halves[gi] = M_ld_data[16*gi +: 16];
        end
    endgenerate

    assign ld_byte = ld_bytes[M_addr_lo];
    assign ld_half = ld_halves[M_addr_lo[1]];

    always_comb begin
        ld_fmt = M_ld_data;
        case (M_funct3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = M_ld_data;
        endcase
    end

    assign L_ready       = (count_reg != CNT_W'(DEPTH));
    assign fifo_nonempty = (count_reg != '0);
    assign L_pending     = fifo_nonempty;

    // A stall cycle masks MEM so the FIFO head is guaranteed the port.
    assign m_eligible = M_valid & (M_reg_write_enable | M_reg_write_enable_f) & ~stall_reg;
    assign pop        = fifo_nonempty & ~m_eligible;
    assign push       = L_valid & L_ready;

    assign head      = fifo_mem[rd_ptr_reg];
    assign head_fp   = head[37];
    assign head_rd   = head[36:32];
    assign head_data = head[31:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {L_is_fp, L_rd, L_data};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        starve_next = '0;
        stall_next  = 1'b0;
        if (fifo_nonempty && !pop) begin
            starve_next = starve_reg + STV_W'(1);
            stall_next  = (starve_next == STV_W'(STARVE_MAX));
        end
    end

    // Port arbitration; x0 integer writes still occupy the slot.
    always_comb begin
        we_next   = 1'b0;
        we_f_next = 1'b0;
        rd_next   = rd_reg;
        data_next = data_reg;
        if (m_eligible) begin
            we_next   = M_reg_write_enable & (M_rd != 5'd0);
            we_f_next = M_reg_write_enable_f;
            rd_next   = M_rd;
            data_next = M_wb_data_sel ? ld_fmt : M_alu_result;
        end else if (pop) begin
            we_next   = ~head_fp & (head_rd != 5'd0);
            we_f_next = head_fp;
            rd_next   = head_rd;
            data_next = head_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
            we_reg     <= 1'b0;
            we_f_reg   <= 1'b0;
            rd_reg     <= '0;
            data_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg  <= count_next;
            starve_reg <= starve_next;
            stall_reg  <= stall_next;
            we_reg     <= we_next;
            we_f_reg   <= we_f_next;
            rd_reg     <= rd_next;
            data_reg   <= data_next;
        end
    end

    assign W_write_enable   = we_reg;
    assign W_write_enable_f = we_f_reg;
    assign W_rd             = rd_reg;
    assign W_rd_data        = data_reg;
    assign W_stall_req      = stall_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected writes, a negedge
// monitor pops and compares every visible register-file write.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_valid;
    logic [4:0]  M_rd;
    logic        M_reg_write_enable;
    logic        M_reg_write_enable_f;
    logic        M_wb_data_sel;
    logic [2:0]  M_funct3;
    logic [1:0]  M_addr_lo;
    logic [31:0] M_alu_result;
    logic [31:0] M_ld_data;
    logic        L_valid;
    logic        L_ready;
    logic [4:0]  L_rd;
    logic        L_is_fp;
    logic [31:0] L_data;
    logic        L_pending;
    logic        W_write_enable;
    logic        W_write_enable_f;
    logic [4:0]  W_rd;
    logic [31:0] W_rd_data;
    logic        W_stall_req;

    typedef struct packed {
        logic        we;
        logic        we_f;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    wr_t mon_a;
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .M_valid(M_valid), .M_rd(M_rd),
        .M_reg_write_enable(M_reg_write_enable),
        .M_reg_write_enable_f(M_reg_write_enable_f),
        .M_wb_data_sel(M_wb_data_sel), .M_funct3(M_funct3),
        .M_addr_lo(M_addr_lo), .M_alu_result(M_alu_result),
        .M_ld_data(M_ld_data),
        .L_valid(L_valid), .L_ready(L_ready), .L_rd(L_rd),
        .L_is_fp(L_is_fp), .L_data(L_data), .L_pending(L_pending),
        .W_write_enable(W_write_enable), .W_write_enable_f(W_write_enable_f),
        .W_rd(W_rd), .W_rd_data(W_rd_data), .W_stall_req(W_stall_req)
    );

    // Monitor: every visible write must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && (W_write_enable || W_write_enable_f)) begin
            mon_a = '{we: W_write_enable, we_f: W_write_enable_f, rd: W_rd, data: W_rd_data};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got we=%b wef=%b rd=%0d data=%h, required no write",
                         mon_a.we, mon_a.we_f, mon_a.rd, mon_a.data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL write: got we=%b wef=%b rd=%0d data=%h, required we=%b wef=%b rd=%0d data=%h",
                             mon_a.we, mon_a.we_f, mon_a.rd, mon_a.data,
                             mon_e.we, mon_e.we_f, mon_e.rd, mon_e.data);
                end else begin
                    $display("write ok: we=%b wef=%b rd=%0d data=%h",
                             mon_a.we, mon_a.we_f, mon_a.rd, mon_a.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    function automatic wr_t mk(input logic we, input logic we_f, input logic [4:0] rd,
                               input logic [31:0] data);
        wr_t w;
        w.we = we; w.we_f = we_f; w.rd = rd; w.data = data;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_idle();
        M_valid = 0; M_rd = 0; M_reg_write_enable = 0; M_reg_write_enable_f = 0;
        M_wb_data_sel = 0; M_funct3 = 0; M_addr_lo = 0; M_alu_result = 0; M_ld_data = 0;
    endtask

    task automatic m_alu(input logic [4:0] rd, input logic fp, input logic [31:0] v);
        M_valid = 1; M_rd = rd; M_reg_write_enable = !fp; M_reg_write_enable_f = fp;
        M_wb_data_sel = 0; M_funct3 = 0; M_addr_lo = 0; M_alu_result = v; M_ld_data = 0;
    endtask

    task automatic m_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] word);
        M_valid = 1; M_rd = rd; M_reg_write_enable = 1; M_reg_write_enable_f = 0;
        M_wb_data_sel = 1; M_funct3 = f3; M_addr_lo = lo; M_alu_result = 32'h0BAD_0BAD;
        M_ld_data = word;
    endtask

    task automatic l_drive(input logic v, input logic [4:0] rd, input logic fp,
                           input logic [31:0] d);
        L_valid = v; L_rd = rd; L_is_fp = fp; L_data = d;
    endtask

    // One long-latency entry starved by back-to-back MEM results.
    task automatic run_starve(input int base);
        int idx_tbl [8] = '{0, 0, 1, 2, 3, 4, 4, 5};
        logic stall_tbl [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, 0, 5'(10 + k), 32'(base + k)));
        exp_q.push_back(mk(1, 0, 5'd7, 32'(base + 'h77)));
        exp_q.push_back(mk(1, 0, 5'd14, 32'(base + 4)));
        exp_q.push_back(mk(1, 0, 5'd15, 32'(base + 5)));
        m_idle();
        l_drive(1, 7, 0, 32'(base + 'h77));
        tick();
        l_drive(0, 0, 0, 0);
        for (int c = 1; c < 8; c++) begin
            m_alu(5'(10 + idx_tbl[c]), 0, 32'(base + idx_tbl[c]));
            @(negedge clk);
            check($sformatf("stall_req_c%0d", c), 32'(W_stall_req), 32'(stall_tbl[c]));
            tick();
        end
        m_idle();
        tick();
        check("starve_pending_drained", 32'(L_pending), 32'd0);
    endtask

    initial begin
        rst = 1;
        m_idle();
        l_drive(0, 0, 0, 0);
        @(negedge clk);
        check("rst_we", 32'(W_write_enable), 32'd0);
        check("rst_we_f", 32'(W_write_enable_f), 32'd0);
        check("rst_rd", 32'(W_rd), 32'd0);
        check("rst_data", W_rd_data, 32'd0);
        check("rst_stall", 32'(W_stall_req), 32'd0);
        check("rst_ready", 32'(L_ready), 32'd1);
        check("rst_pending", 32'(L_pending), 32'd0);
        tick();
        rst = 0;
        tick();

        // Load formatting vectors.
        m_load(5, 3'b000, 2, 32'h12F45678); exp_q.push_back(mk(1, 0, 5, 32'hFFFFFFF4)); tick();
        m_load(5, 3'b100, 2, 32'h12F45678); exp_q.push_back(mk(1, 0, 5, 32'h000000F4)); tick();
        m_load(5, 3'b101, 2, 32'h12F45678); exp_q.push_back(mk(1, 0, 5, 32'h000012F4)); tick();
        m_load(6, 3'b001, 0, 32'h12F48678); exp_q.push_back(mk(1, 0, 6, 32'hFFFF8678)); tick();
        m_load(6, 3'b000, 3, 32'h12F45678); exp_q.push_back(mk(1, 0, 6, 32'h00000012)); tick();
        m_load(8, 3'b010, 1, 32'h89ABCDEF); exp_q.push_back(mk(1, 0, 8, 32'h89ABCDEF)); tick();
        m_load(8, 3'b011, 3, 32'h13579BDF); exp_q.push_back(mk(1, 0, 8, 32'h13579BDF)); tick();
        m_alu(9, 0, 32'h00C0FFEE);          exp_q.push_back(mk(1, 0, 9, 32'h00C0FFEE)); tick();

        // x0 integer write is suppressed; f0 write is allowed.
        m_alu(0, 0, 32'hDEADBEEF);
        tick();
        m_alu(0, 1, 32'h40000000);
        exp_q.push_back(mk(0, 1, 0, 32'h40000000));
        @(negedge clk);
        check("x0_we", 32'(W_write_enable), 32'd0);
        check("x0_we_f", 32'(W_write_enable_f), 32'd0);
        tick();
        m_idle();
        tick();
        tick();

        // Fill the FIFO behind x0 blockers, then drain with MEM idle.
        m_alu(0, 0, 32'h11111111);
        l_drive(1, 3, 1, 32'h3F800000); exp_q.push_back(mk(0, 1, 3, 32'h3F800000)); tick();
        l_drive(1, 4, 0, 32'd7);        exp_q.push_back(mk(1, 0, 4, 32'd7));        tick();
        l_drive(1, 9, 0, 32'h99);       exp_q.push_back(mk(1, 0, 9, 32'h99));
        @(negedge clk);
        check("full_ready_c2", 32'(L_ready), 32'd0);
        check("full_pending_c2", 32'(L_pending), 32'd1);
        tick();
        m_idle();
        @(negedge clk);
        check("full_ready_c3", 32'(L_ready), 32'd0);
        tick();
        @(negedge clk);
        check("full_ready_c4", 32'(L_ready), 32'd1);
        tick();
        l_drive(0, 0, 0, 0);
        tick(); tick(); tick();
        check("fill_drained", 32'(L_pending), 32'd0);

        // Starvation: stall after exactly STARVE_MAX blocked cycles, twice.
        run_starve(32'h1000);
        run_starve(32'h2000);

        // Push and pop together at one entry, across pointer wrap.
        m_idle();
        for (int i = 0; i < 8; i++) begin
            l_drive(1, 5'(16 + i), i[0], 32'hA0000000 + 32'(i));
            exp_q.push_back(mk(!i[0], i[0], 5'(16 + i), 32'hA0000000 + 32'(i)));
            tick();
            check($sformatf("wrap_pending_%0d", i), 32'(L_pending), 32'd1);
            check($sformatf("wrap_ready_%0d", i), 32'(L_ready), 32'd1);
        end
        l_drive(0, 0, 0, 0);
        tick(); tick();
        check("wrap_drained", 32'(L_pending), 32'd0);

        // Reset mid-run with two entries queued discards them.
        m_alu(0, 0, 32'h5555AAAA);
        l_drive(1, 12, 0, 32'hBAD00001); tick();
        l_drive(1, 13, 0, 32'hBAD00002); tick();
        l_drive(0, 0, 0, 0);
        check("pre_rst_ready", 32'(L_ready), 32'd0);
        check("pre_rst_pending", 32'(L_pending), 32'd1);
        check("pre_rst_data", W_rd_data, 32'h5555AAAA);
        tick();
        rst = 1;
        m_idle();
        #1;
        check("midrst_pending", 32'(L_pending), 32'd0);
        check("midrst_ready", 32'(L_ready), 32'd1);
        check("midrst_we", 32'(W_write_enable), 32'd0);
        check("midrst_we_f", 32'(W_write_enable_f), 32'd0);
        check("midrst_rd", 32'(W_rd), 32'd0);
        check("midrst_data", W_rd_data, 32'd0);
        check("midrst_stall", 32'(W_stall_req), 32'd0);
        tick(); tick();
        rst = 0;
        tick(); tick(); tick(); tick();
        check("post_rst_pending", 32'(L_pending), 32'd0);

        tick(); tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
